nibble_drive_seq: RTL and testbench

Upstream driver stage for the 4-bit gate-level consumer. It buffers incoming 4-bit words and per-bit high-impedance masks in a small FIFO. It then presents them one beat at a time on a `wire logic [4:1]` bus, together with a `real` fill-level output that the consumer uses as its enable. Flow control is valid/ready on the input, a hold signal on the output, and a synchronous flush.

---
 rtl/nibble_drive_pkg.sv | 32 +++
 rtl/nibble_fifo.sv | 65 ++++++
 rtl/nibble_drive_seq.sv | 139 +++++++++++++
 tb/tb_nibble_drive_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/nibble_drive_pkg.sv
// ============================================================================
// Module   : nibble_drive_pkg
// Brief    : Shared types and constants for the nibble drive sequencer.
//            NIBBLE_DRIVE_ZMASK_EN selects whether the release mask is stored.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nibble_drive_pkg;

  localparam int c_default_depth = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } nd_state_t;

  typedef struct packed {
    logic [3:0] data;
    logic [3:0] zmask;
  } nd_entry_t;

`ifdef NIBBLE_DRIVE_ZMASK_EN
  localparam int c_entry_w = $bits(nd_entry_t);
`else
  localparam int c_entry_w = 4;
`endif

endpackage

`default_nettype wire

// File: rtl/nibble_fifo.sv
// ============================================================================
// Module   : nibble_fifo
// Brief    : Power-of-two circular buffer with push/pop/clear and occupancy.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wptr;
  logic [c_aw-1:0]  r_rptr;
  logic [c_aw:0]    r_count;

  // Storage carries no reset; only occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data = r_mem[r_rptr];
  assign count   = r_count;

endmodule

`default_nettype wire

// File: rtl/nibble_drive_seq.sv
// ============================================================================
// Module   : nibble_drive_seq
// Brief    : Buffers nibbles and drives them one beat at a time on a 4-bit bus;
//            NIBBLE_DRIVE_ZMASK_EN enables per-bit release to high impedance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_drive_seq
  import nibble_drive_pkg::*;
#(
  parameter int DEPTH = c_default_depth,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:1]       in_data,
  input  logic [4:1]       in_zmask,
  input  logic             flush,
  input  logic             out_hold,
  output wire logic [4:1]  out_data,
  output logic             out_valid,
  output real              out_lvl,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam int c_cw = $clog2(DEPTH) + 1;
  localparam logic [c_cw-1:0] c_full = c_cw'(DEPTH);

  nd_state_t            r_state;
  nd_state_t            w_state_nxt;
  logic                 w_push;
  logic                 w_pop;
  logic [c_cw-1:0]      w_count;
  logic [c_entry_w-1:0] w_wr;
  logic [c_entry_w-1:0] w_rd;
  logic [c_entry_w-1:0] r_out;
  logic                 r_valid;
  logic [CNT_W-1:0]     r_beat;

  assign in_ready = (w_count != c_full) && (r_state != FLUSH);
  assign w_push   = in_valid && in_ready;

  nibble_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (c_entry_w)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push && !flush),
    .pop     (w_pop && !flush),
    .clear   (flush),
    .wr_data (w_wr),
    .rd_data (w_rd),
    .count   (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_push) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_pop = !out_hold && (w_count != '0);
        // Drop back to IDLE once the last entry leaves with nothing arriving.
        if (!w_push && ((w_count == '0) || (w_count == c_cw'(1) && w_pop))) begin
          w_state_nxt = IDLE;
        end
      end
      FLUSH: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (flush) begin
      w_state_nxt = FLUSH;
    end
  end

  // Output beat register: loads on pop, holds under stall, empties only when
  // an unstalled cycle finds nothing to deliver.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_out   <= '0;
      r_beat  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_pop) begin
      r_valid <= 1'b1;
      r_out   <= w_rd;
      r_beat  <= r_beat + 1'b1;
    end else if (!out_hold && (w_count == '0)) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign beat_cnt  = r_beat;
  assign out_lvl   = real'(w_count) / real'(DEPTH);

`ifdef NIBBLE_DRIVE_ZMASK_EN
  nd_entry_t w_wr_entry;
  nd_entry_t w_out_entry;

  assign w_wr_entry  = '{data: in_data, zmask: in_zmask};
  assign w_wr        = w_wr_entry;
  assign w_out_entry = r_out;

  for (genvar i = 1; i <= 4; i++) begin : g_bit
    assign out_data[i] = (r_valid && !w_out_entry.zmask[i-1]) ? w_out_entry.data[i-1] : 1'bz;
  end
`else
  logic w_unused_zmask;

  assign w_wr           = in_data;
  assign w_unused_zmask = ^in_zmask;
  assign out_data       = r_valid ? r_out : 4'b0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nibble_drive_seq.sv
// ============================================================================
// Module   : tb_nibble_drive_seq
// Brief    : Directed plus random checks of nibble_drive_seq against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_drive_seq;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [4:1]       in_data;
  logic [4:1]       in_zmask;
  logic             flush;
  logic             out_hold;
  wire logic [4:1]  out_data;
  logic             out_valid;
  real              out_lvl;
  logic [CNT_W-1:0] beat_cnt;

  int vectors;
  int miscompares;

  // Reference model: queue of {data, zmask}, delivered beat, beat total.
  logic [7:0] mq[$];
  bit         mvalid;
  logic [3:0] mdata;
  logic [3:0] mzm;
  int         mbeats;
  bit         mflush;

  nibble_drive_seq #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_zmask  (in_zmask),
    .flush     (flush),
    .out_hold  (out_hold),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_lvl   (out_lvl),
    .beat_cnt  (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] exp_out();
    logic [3:0] r;
`ifdef NIBBLE_DRIVE_ZMASK_EN
    for (int i = 0; i < 4; i++) begin
      r[i] = (mvalid && !mzm[i]) ? mdata[i] : 1'bz;
    end
`else
    r = mvalid ? mdata : 4'b0000;
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_lvl(input real obs, input real exp);
    vectors++;
    assert (obs == exp) else begin
      miscompares++;
      $error("FAIL out_lvl: observed %f expected %f", obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", {31'd0, out_valid}, {31'd0, mvalid});
    chk("out_data", {28'd0, out_data}, {28'd0, exp_out()});
    chk("beat_cnt", {30'd0, beat_cnt}, mbeats);
    chk("in_ready", {31'd0, in_ready}, {31'd0, (mq.size() != DEPTH) && !mflush});
    chk_lvl(out_lvl, real'(mq.size()) / real'(DEPTH));
  endtask

  task automatic model_reset();
    mq.delete();
    mvalid = 1'b0;
    mdata  = 4'h0;
    mzm    = 4'h0;
    mbeats = 0;
    mflush = 1'b0;
  endtask

  task automatic step(input bit v, input logic [3:0] d, input logic [3:0] z,
                      input bit h, input bit f);
    bit rdy;
    bit push;
    bit pop;
    in_valid = v;
    in_data  = d;
    in_zmask = z;
    out_hold = h;
    flush    = f;
    rdy  = (mq.size() != DEPTH) && !mflush;
    push = v && rdy;
    pop  = !h && (mq.size() != 0);
    @(posedge clk);
    if (f) begin
      mq.delete();
      mvalid = 1'b0;
      mflush = 1'b1;
    end else begin
      mflush = 1'b0;
      if (pop) begin
        {mdata, mzm} = mq.pop_front();
        mvalid = 1'b1;
        mbeats = (mbeats + 1) % (1 << CNT_W);
      end else if (!h) begin
        mvalid = 1'b0;
      end
      if (push) begin
        mq.push_back({d, z});
      end
    end
    #1;
    check_all();
  endtask

  task automatic async_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    out_hold = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 4'h0;
    in_zmask = 4'h0;
    flush    = 1'b0;
    out_hold = 1'b0;
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all();

    // Basic flow A, 5, F back-to-back
    step(1'b1, 4'hA, 4'h0, 1'b0, 1'b0);
    step(1'b1, 4'h5, 4'h0, 1'b0, 1'b0);
    step(1'b1, 4'hF, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("basic_beats", {30'd0, beat_cnt}, 32'd3);

    // Fill under stall, fifth word refused, then drain
    for (int i = 0; i < 5; i++) step(1'b1, 4'(i + 3), 4'h0, 1'b1, 1'b0);
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

    // Flush while pushing and popping with two entries
    step(1'b1, 4'h7, 4'h0, 1'b1, 1'b0);
    step(1'b1, 4'h8, 4'h0, 1'b1, 1'b0);
    step(1'b1, 4'h9, 4'h0, 1'b0, 1'b1);
    step(1'b1, 4'h1, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

    // Release mask pattern
    step(1'b1, 4'b1111, 4'b0101, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

    // Asynchronous reset with three entries held
    for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 10), 4'h0, 1'b1, 1'b0);
    async_reset();

    // Counter wrap after five beats
    for (int i = 0; i < 5; i++) step(1'b1, 4'(i), 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("wrap", {30'd0, beat_cnt}, 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
